// File: rtl/sram16_pkg.sv
// Shared types and error codes for the 16-bit SRAM responder.
// Optional SRAM_STATS_EN adds pair counters in the top and the pair checker.
package sram16_pkg;

    typedef enum logic [1:0] {IDLE, HI_RD, HI_WR} pair_state_t;

    typedef enum logic [1:0] {NOP, RD, WR, ILL} acc_kind_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_ILL   = 3'd1;
    localparam logic [2:0] ERR_PAIR  = 3'd2;
    localparam logic [2:0] ERR_RANGE = 3'd3;

    function automatic acc_kind_t decode_acc(input logic we_n, input logic re_n);
        acc_kind_t k;
        case ({we_n, re_n})
            2'b01:   k = WR;
            2'b10:   k = RD;
            2'b00:   k = ILL;
            default: k = NOP;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sram16_pair_chk.sv
// Even-then-odd halfword pairing checker; with SRAM_STATS_EN defined it also
// counts completed read and write pairs.
module sram16_pair_chk
    import sram16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acc_vld,
    input  logic        acc_wr,
    input  logic [15:0] addr,
    output logic        pair_err
`ifdef SRAM_STATS_EN
    ,
    output logic [15:0] rd_words,
    output logic [15:0] wr_words
`endif
);

    pair_state_t state, state_n;
    logic [14:0] word, word_n;
    logic        pair_match;

    assign pair_match = ((state == HI_RD && !acc_wr) || (state == HI_WR && acc_wr))
                        && addr[0] && (addr[15:1] == word);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
        word <= word_n;
    end

    // A mismatch is handled as a fresh access from IDLE
    always_comb begin
        state_n  = state;
        word_n   = word;
        pair_err = 1'b0;
        if (acc_vld) begin
            if (pair_match) begin
                state_n = IDLE;
            end else begin
                pair_err = (state != IDLE) || addr[0];
                if (addr[0]) begin
                    state_n = IDLE;
                end else begin
                    state_n = acc_wr ? HI_WR : HI_RD;
                    word_n  = addr[15:1];
                end
            end
        end
    end

`ifdef SRAM_STATS_EN
    logic pair_done;
    assign pair_done = acc_vld && pair_match;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_words <= '0;
            wr_words <= '0;
        end else if (pair_done) begin
            if (acc_wr) wr_words <= wr_words + 16'd1;
            else        rd_words <= rd_words + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/sram16_responder.sv
// Responder for the 16-bit external SRAM pin interface with fixed read latency.
// Define SRAM_STATS_EN to expose rd_words/wr_words completed-pair counters.
module sram16_responder
    import sram16_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        we_n,
    input  logic        re_n,
    input  logic [1:0]  be_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        err,
    output logic [2:0]  err_code
`ifdef SRAM_STATS_EN
    ,
    output logic [15:0] rd_words,
    output logic [15:0] wr_words
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    acc_kind_t         kind;
    logic              out_of_range;
    logic              acc_rw;
    logic              do_wr;
    logic              do_rd;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       rd_word;
    logic              pair_err;
    logic [2:0]        cause;

    logic [15:0]       mem [DEPTH];
    logic [15:0]       data_p [READ_LAT];
    logic [READ_LAT-1:0] vld_p;

    assign kind         = cs ? decode_acc(we_n, re_n) : NOP;
    assign out_of_range = (addr >> ADDR_W) != 16'd0;
    assign acc_rw       = (kind == RD) || (kind == WR);
    assign do_wr        = (kind == WR) && !out_of_range;
    assign do_rd        = (kind == RD);
    assign idx          = addr[ADDR_W-1:0];
    assign rd_word      = out_of_range ? 16'h0000 : mem[idx];

    // Array is deliberately left unreset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (rst_n && do_wr) begin
            if (!be_n[0]) mem[idx][7:0]  <= wdata[7:0];
            if (!be_n[1]) mem[idx][15:8] <= wdata[15:8];
        end
    end

    // p0 captures the read at the strobe edge; last stage drives the pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < READ_LAT; i++) data_p[i] <= '0;
        end else begin
            vld_p[0]  <= do_rd;
            data_p[0] <= do_rd ? rd_word : 16'h0000;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign rdata  = data_p[READ_LAT-1];
    assign rvalid = vld_p[READ_LAT-1];

    sram16_pair_chk u_pair_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .acc_vld  (acc_rw),
        .acc_wr   (kind == WR),
        .addr     (addr),
        .pair_err (pair_err)
`ifdef SRAM_STATS_EN
        ,
        .rd_words (rd_words),
        .wr_words (wr_words)
`endif
    );

    // When one access has several faults, ILL beats RANGE beats PAIR
    assign cause = (kind == ILL)            ? ERR_ILL   :
                   (acc_rw && out_of_range) ? ERR_RANGE :
                   pair_err                 ? ERR_PAIR  : ERR_NONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (!err && cause != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= cause;
        end
    end

endmodule

// File: tb/tb_sram16_responder.sv
// Bench for sram16_responder: vector table, directed corner sequences and a
// randomized run against a behavioural model (honours SRAM_STATS_EN).
module tb_sram16_responder;

    localparam int LA = 2;
    localparam int LB = 3;

    typedef struct packed {
        logic        cs, we_n, re_n;
        logic [1:0]  be_n;
        logic [15:0] addr, wdata;
    } acc_t;

    typedef struct {
        acc_t        a;
        logic        rv;
        logic [15:0] rd;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_cs, a_we_n, a_re_n, a_rvalid, a_err;
    logic [1:0]  a_be_n;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_err_code;
    logic        b_rst_n, b_cs, b_we_n, b_re_n, b_rvalid, b_err;
    logic [1:0]  b_be_n;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_err_code;
`ifdef SRAM_STATS_EN
    logic [15:0] a_rdw, a_wrw, b_rdw, b_wrw;
`endif

    sram16_responder #(.ADDR_W(10), .READ_LAT(LA)) u_a (
        .clk(clk), .rst_n(a_rst_n), .cs(a_cs), .we_n(a_we_n), .re_n(a_re_n),
        .be_n(a_be_n), .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
        .rvalid(a_rvalid), .err(a_err), .err_code(a_err_code)
`ifdef SRAM_STATS_EN
        , .rd_words(a_rdw), .wr_words(a_wrw)
`endif
    );

    sram16_responder #(.ADDR_W(10), .READ_LAT(LB)) u_b (
        .clk(clk), .rst_n(b_rst_n), .cs(b_cs), .we_n(b_we_n), .re_n(b_re_n),
        .be_n(b_be_n), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
        .rvalid(b_rvalid), .err(b_err), .err_code(b_err_code)
`ifdef SRAM_STATS_EN
        , .rd_words(b_rdw), .wr_words(b_wrw)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state for DUT b
    logic [15:0] mref [16];
    bit          m_err;
    logic [2:0]  m_code;
    bit          open, open_wr;
    logic [14:0] open_word;
    int          m_rdw, m_wrw;
    rd_t         rq[$];
    acc_t        plan[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input acc_t t);
        if (!sel) begin
            a_cs = t.cs; a_we_n = t.we_n; a_re_n = t.re_n;
            a_be_n = t.be_n; a_addr = t.addr; a_wdata = t.wdata;
        end else begin
            b_cs = t.cs; b_we_n = t.we_n; b_re_n = t.re_n;
            b_be_n = t.be_n; b_addr = t.addr; b_wdata = t.wdata;
        end
    endtask

    function automatic acc_t mk(input logic cs, we_n, re_n, input logic [1:0] be,
                                input logic [15:0] ad, wd);
        acc_t t;
        t.cs = cs; t.we_n = we_n; t.re_n = re_n; t.be_n = be; t.addr = ad; t.wdata = wd;
        return t;
    endfunction

    function automatic acc_t nop_acc();
        return mk(1'b0, 1'b1, 1'b1, 2'b11, 16'h0, 16'h0);
    endfunction

    function automatic logic rv(input bit sel);
        return sel ? b_rvalid : a_rvalid;
    endfunction

    function automatic logic [15:0] rd(input bit sel);
        return sel ? b_rdata : a_rdata;
    endfunction

    task automatic reset_dut(input bit sel);
        if (!sel) a_rst_n = 1'b0; else b_rst_n = 1'b0;
        drive(sel, nop_acc());
        tick();
        tick();
        if (!sel) a_rst_n = 1'b1; else b_rst_n = 1'b1;
    endtask

    task automatic wr(input bit sel, input logic [15:0] ad, wd);
        drive(sel, mk(1'b1, 1'b0, 1'b1, 2'b00, ad, wd));
        tick();
        drive(sel, nop_acc());
    endtask

    task automatic read_expect(input bit sel, input logic [15:0] ad, exp, input int lat);
        int n = 1;
        drive(sel, mk(1'b1, 1'b1, 1'b0, 2'b11, ad, 16'h0));
        tick();
        drive(sel, nop_acc());
        while (!rv(sel) && n < 8) begin
            tick();
            n++;
        end
        check($sformatf("rd_latency[%h]", ad), n, lat);
        check($sformatf("rd_data[%h]", ad), rd(sel), exp);
        tick();
    endtask

    function automatic acc_t rnd_acc(input bit isw, input logic [15:0] ad);
        return mk(1'b1, !isw, isw, 2'($urandom_range(0, 3)), ad, 16'($urandom));
    endfunction

    task automatic plan_more();
        int          r;
        logic [15:0] w;
        bit          isw;
        int          gaps;
        acc_t        t;
        r    = $urandom_range(0, 99);
        w    = 16'h0050 + 16'(2 * $urandom_range(0, 7));
        isw  = 1'($urandom_range(0, 1));
        gaps = $urandom_range(0, 2);
        if ($urandom_range(0, 9) == 0) w = w | (($urandom_range(0, 1) != 0) ? 16'h0400 : 16'h8000);
        if (r < 75) begin
            plan.push_back(rnd_acc(isw, w));
            for (int g = 0; g < gaps; g++) begin
                t = nop_acc();
                t.cs = 1'($urandom_range(0, 1));
                plan.push_back(t);
            end
            plan.push_back(rnd_acc(isw, w | 16'h1));
        end else if (r < 85) begin
            t = rnd_acc(1'b0, w);
            t.we_n = 1'b0;
            plan.push_back(t);
        end else if (r < 95) begin
            plan.push_back(rnd_acc(isw, w | 16'($urandom_range(0, 1))));
        end else begin
            plan.push_back(rnd_acc(isw, w));
            plan.push_back(rnd_acc(!isw, w | 16'h1));
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_code = 3'd0; open = 0; m_rdw = 0; m_wrw = 0;
        rq.delete();
        plan.delete();
    endtask

    task automatic model_edge(input acc_t a, input int cyc);
        bit         ill, isrd, iswr, oor, perr;
        logic [2:0] cause;
        ill  = a.cs && !a.we_n && !a.re_n;
        isrd = a.cs && a.we_n && !a.re_n;
        iswr = a.cs && !a.we_n && a.re_n;
        oor  = (a.addr >> 10) != 16'd0;
        perr = 0;
        if (isrd || iswr) begin
            if (open && open_wr == iswr && a.addr[0] && a.addr[15:1] == open_word) begin
                open = 0;
                if (iswr) m_wrw = (m_wrw + 1) % 65536; else m_rdw = (m_rdw + 1) % 65536;
            end else begin
                if (open || a.addr[0]) perr = 1;
                open      = !a.addr[0];
                open_wr   = iswr;
                open_word = a.addr[15:1];
            end
        end
        if (iswr && !oor) begin
            if (!a.be_n[0]) mref[a.addr[3:0]][7:0]  = a.wdata[7:0];
            if (!a.be_n[1]) mref[a.addr[3:0]][15:8] = a.wdata[15:8];
        end
        if (isrd) rq.push_back('{due: cyc + LB - 1, d: oor ? 16'h0 : mref[a.addr[3:0]]});
        cause = ill ? 3'd1 : ((isrd || iswr) && oor) ? 3'd3 : perr ? 3'd2 : 3'd0;
        if (!m_err && cause != 3'd0) begin
            m_err  = 1;
            m_code = cause;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        acc_t a;
        int   cyc;
        bit   exp_rv;
        logic [15:0] exp_d;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        drive(0, nop_acc());
        drive(1, nop_acc());

        // reset state
        reset_dut(0);
        check("reset_rdata", a_rdata, 16'h0);
        check("reset_rvalid", a_rvalid, 1'b0);
        check("reset_err", a_err, 1'b0);
        check("reset_err_code", a_err_code, 3'd0);

        // word write/read and byte enables, per-cycle vectors
        tbl[0]  = '{mk(1, 0, 1, 2'b00, 16'h0010, 16'hDEAD), 0, 16'h0};
        tbl[1]  = '{mk(1, 0, 1, 2'b00, 16'h0011, 16'hBEEF), 0, 16'h0};
        tbl[2]  = '{mk(1, 1, 0, 2'b11, 16'h0010, 16'h0),    0, 16'h0};
        tbl[3]  = '{mk(1, 1, 0, 2'b00, 16'h0011, 16'h0),    1, 16'hDEAD};
        tbl[4]  = '{nop_acc(),                              1, 16'hBEEF};
        tbl[5]  = '{nop_acc(),                              0, 16'h0};
        tbl[6]  = '{mk(1, 0, 1, 2'b00, 16'h0020, 16'h1234), 0, 16'h0};
        tbl[7]  = '{mk(1, 0, 1, 2'b00, 16'h0021, 16'h5678), 0, 16'h0};
        tbl[8]  = '{mk(1, 0, 1, 2'b01, 16'h0020, 16'hABFF), 0, 16'h0};
        tbl[9]  = '{mk(1, 0, 1, 2'b11, 16'h0021, 16'hFFFF), 0, 16'h0};
        tbl[10] = '{mk(1, 1, 0, 2'b11, 16'h0020, 16'h0),    0, 16'h0};
        tbl[11] = '{mk(1, 1, 0, 2'b11, 16'h0021, 16'h0),    1, 16'hAB34};
        tbl[12] = '{nop_acc(),                              1, 16'h5678};
        tbl[13] = '{nop_acc(),                              0, 16'h0};
        for (int i = 0; i < 14; i++) begin
            drive(0, tbl[i].a);
            tick();
            check($sformatf("vec%0d_rvalid", i), a_rvalid, tbl[i].rv);
            if (tbl[i].rv) check($sformatf("vec%0d_rdata", i), a_rdata, tbl[i].rd);
            check($sformatf("vec%0d_err", i), a_err, 1'b0);
        end
`ifdef SRAM_STATS_EN
        check("vec_rd_words", a_rdw, 16'd2);
        check("vec_wr_words", a_wrw, 16'd3);
`endif

        // illegal strobe pair, then a range error that must not overwrite the code
        reset_dut(0);
        drive(0, mk(1, 0, 0, 2'b00, 16'h0020, 16'hFFFF));
        tick();
        drive(0, nop_acc());
        check("ill_err", a_err, 1'b1);
        check("ill_err_code", a_err_code, 3'd1);
        for (int i = 0; i < 3; i++) begin
            check("ill_no_rvalid", a_rvalid, 1'b0);
            tick();
        end
        read_expect(0, 16'h0400, 16'h0000, LA);
        read_expect(0, 16'h0401, 16'h0000, LA);
        check("ill_code_kept", a_err_code, 3'd1);
        read_expect(0, 16'h0020, 16'hAB34, LA);
        read_expect(0, 16'h0021, 16'h5678, LA);

        // orphan/mismatch: RD even then WR odd
        reset_dut(0);
        wr(0, 16'h0030, 16'h3030);
        wr(0, 16'h0031, 16'h3131);
        read_expect(0, 16'h0030, 16'h3030, LA);
        check("pair_err_clear", a_err, 1'b0);
        wr(0, 16'h0031, 16'h7777);
        tick();
        check("pair_err", a_err, 1'b1);
        check("pair_err_code", a_err_code, 3'd2);
        read_expect(0, 16'h0031, 16'h7777, LA);
`ifdef SRAM_STATS_EN
        check("pair_wr_words", a_wrw, 16'd1);
        check("pair_rd_words_idle", a_rdw, 16'd0);
`endif

        // out-of-range reads return zero; writes do not alias
        reset_dut(0);
        wr(0, 16'h0000, 16'h1111);
        wr(0, 16'h0001, 16'h2222);
        read_expect(0, 16'h0400, 16'h0000, LA);
        check("range_err_code", a_err_code, 3'd3);
        read_expect(0, 16'h0401, 16'h0000, LA);
        wr(0, 16'h0400, 16'h5555);
        wr(0, 16'h0401, 16'h6666);
        read_expect(0, 16'h0000, 16'h1111, LA);
        read_expect(0, 16'h0001, 16'h2222, LA);
        check("range_code_kept", a_err_code, 3'd3);
`ifdef SRAM_STATS_EN
        check("range_rd_words", a_rdw, 16'd2);
        check("range_wr_words", a_wrw, 16'd2);
`endif

        // reset while a read is in flight
        reset_dut(1);
        wr(1, 16'h0040, 16'hCAFE);
        wr(1, 16'h0041, 16'hF00D);
        drive(1, mk(1, 1, 0, 2'b11, 16'h0040, 16'h0));
        tick();
        b_rst_n = 1'b0;
        drive(1, nop_acc());
        tick();
        b_rst_n = 1'b1;
        check("midrst_rdata", b_rdata, 16'h0);
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_rvalid", b_rvalid, 1'b0);
            tick();
        end
        read_expect(1, 16'h0040, 16'hCAFE, LB);
        read_expect(1, 16'h0041, 16'hF00D, LB);

        // randomized traffic on b against the model
        reset_dut(1);
        model_reset();
        for (int i = 0; i < 16; i++)
            plan.push_back(mk(1, 0, 1, 2'b00, 16'h0050 + 16'(i), 16'($urandom)));
        cyc = 0;
        for (int seg = 0; seg < 10; seg++) begin
            if (seg > 0) begin
                b_rst_n = 1'b0;
                drive(1, nop_acc());
                tick();
                b_rst_n = 1'b1;
                model_reset();
            end
            for (int k = 0; k < 60; k++) begin
                if (plan.size() == 0) plan_more();
                a = plan.pop_front();
                drive(1, a);
                tick();
                cyc++;
                model_edge(a, cyc);
                exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
                exp_d  = 16'h0;
                if (exp_rv) exp_d = rq.pop_front().d;
                check("rnd_rvalid", b_rvalid, exp_rv);
                if (exp_rv) check("rnd_rdata", b_rdata, exp_d);
                check("rnd_err", b_err, m_err);
                check("rnd_err_code", b_err_code, m_code);
`ifdef SRAM_STATS_EN
                check("rnd_rd_words", b_rdw, 16'(m_rdw));
                check("rnd_wr_words", b_wrw, 16'(m_wrw));
`endif
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram16_responder.md
Name: sram16_responder

Overview:
- Synthesizable responder for the 16-bit external SRAM pin interface driven by the core's RAM controller; used as on-chip backing store in FPGA builds and as the bench target for controller verification.
- Accepts cs/we_n/re_n/be_n strobes each clk, stores 16-bit halfwords and returns read data after a fixed latency.
- Tracks even-then-odd halfword pairing so 32-bit transfers split by the controller are checked: high half at addr[0]=0, low half at addr[0]=1.

Parameters:
- ADDR_W, 10, implemented halfword address bits; depth = 2**ADDR_W; range 4..16.
- READ_LAT, 1, cycles from read strobe to rvalid; range 1..4.

Ports:
- clk  in  1  sole clock, posedge
- rst_n  in  1  synchronous active-low reset
- cs  in  1  chip select, active high
- we_n  in  1  write strobe, active low
- re_n  in  1  read strobe, active low
- be_n  in  2  byte enables, active low; [1]=bits 15:8, [0]=bits 7:0
- addr  in  16  halfword address; bit 0 = half select
- wdata  in  16  write data
- rdata  out  16  read data, registered
- rvalid  out  1  one-cycle pulse, rdata valid
- err  out  1  sticky protocol error flag
- err_code  out  3  first error cause, latched with err

Behaviour:
- Reset (rst_n=0 at posedge): rdata=0, rvalid=0, err=0, err_code=0, read pipeline cleared, pair FSM to IDLE, stats counters=0. Memory array is not reset; contents are preserved across reset.
- Access decode, sampled at posedge, only when cs=1; cs=0 means no access and no FSM movement:
  - WR: we_n=0, re_n=1.
  - RD: re_n=0, we_n=1.
  - ILL: both strobes low.
  - NOP: both strobes high.
- WR: each byte with be_n[i]=0 is written at this edge; be_n=2'b11 writes nothing and is not an error.
- RD: rdata is presented with rvalid=1 exactly READ_LAT cycles after the strobe edge. be_n is ignored on reads; the full halfword is returned.
- Back-to-back RD every cycle is supported: the pipeline carries one entry per stage, giving one rvalid per read.
- WR at edge N followed by RD of the same address at edge N+1 returns the new data.
- Out of range: if any addr[15:ADDR_W] bit is 1, the access is ignored (no write; a read still returns 16'h0000 with rvalid) and err is raised with code 3'd3.
- ILL: no write, no read; err raised with code 3'd1.
- err/err_code: the first error sets both and holds them until reset. Later errors do not overwrite err_code.
- Pair FSM:
  - States IDLE, HI_RD, HI_WR. Stored: pair word address addr[15:1].
  - IDLE: RD/WR with addr[0]=0 goes to HI_RD/HI_WR and stores the word address. RD/WR with addr[0]=1 raises err code 3'd2 (orphan low half) and stays in IDLE.
  - HI_x: matching access type, addr[0]=1 and same word address completes the pair and returns to IDLE.
  - HI_x: any other RD/WR (type change, addr[0]=0, different word) raises err 3'd2 and is treated as a new access from IDLE, so an even-address access re-enters HI_x.
  - NOP, cs=0 and ILL do not move the FSM. Gaps between the two halves are legal.
  - Out-of-range accesses still drive the FSM.
- Reset mid-read: in-flight pipeline entries are discarded; no rvalid after reset.

Optional Feature:
- Macro SRAM_STATS_EN.
- Defined: adds outputs rd_words[15:0] and wr_words[15:0]. Each increments by 1 on every completed pair of its type, wraps 16'hFFFF -> 0, and resets to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sram16_pkg holds:
  - pair FSM state enum (IDLE, HI_RD, HI_WR);
  - err_code constants: ERR_NONE=0, ERR_ILL=1, ERR_PAIR=2, ERR_RANGE=3;
  - access-kind enum (NOP, RD, WR, ILL).
- One sub-module: sram16_pair_chk (pair FSM plus optional counters). Memory array and read pipeline stay in the top.

Test Plan:
- Word write/read, READ_LAT=2: WR addr 0x0010 data 0xDEAD, WR 0x0011 data 0xBEEF, RD 0x0010, RD 0x0011 -> rdata 0xDEAD then 0xBEEF on consecutive rvalid pulses, each 2 cycles after its strobe; err=0; rd_words=1, wr_words=1.
- Byte enables: WR 0x0020 data 0x1234 be_n=00, then WR 0x0020 data 0xAB00 be_n=01, RD -> 0xAB34.
- Illegal strobe: we_n=0, re_n=0, cs=1 -> no rvalid, memory unchanged, err=1, err_code=1; a later range error leaves err_code=1.
- Orphan/mismatch: RD 0x0030 then WR 0x0031 -> err_code=2, FSM in IDLE, wr_words unchanged.
- Range, ADDR_W=10: RD 0x0400 -> rvalid with rdata 0x0000, err_code=3; WR 0x0400 -> location 0x0000 not aliased.
- Reset mid-read, READ_LAT=3: RD, then rst_n=0 one cycle later -> no rvalid; memory data written before reset still reads back afterwards.
